image_half_sequencer: RTL and testbench
=======================================

Name: image_half_sequencer

Overview:
- Controller that drives the image-halving datapath across a multi-octave pyramid pass.
- On start, it raster-scans the source image buffer through a fixed-latency BRAM read port and feeds x/y/valid to the halver, aligned with the returned pixel data.
- It counts the pixels the halver writes and ping-pongs between two image banks for OCTAVES successive halvings.
- It sits between the top-level SIFT pipeline control and the halver/BRAM pair.

Parameters:
- BIT_DEPTH, 8, pixel width; passed through only for consistency with the halver.
- WIDTH, 64, octave-0 source image width in pixels; power of two, at most 256.
- HEIGHT, 64, octave-0 source image height in pixels; power of two, at most 256.
- OCTAVES, 3, number of successive halvings per start; WIDTH>>OCTAVES and HEIGHT>>OCTAVES must each be at least 1.
- BRAM_LATENCY, 2, cycles from src_rd_en_out/src_addr_out to valid read data.

Ports:
- clk_in, input, 1, system clock.
- rst_n_in, input, 1, asynchronous active-low reset.
- start_in, input, 1, single-cycle request to begin a pyramid pass; ignored while busy_out=1.
- src_addr_out, output, 16, source-bank read address = y*cur_w + x.
- src_rd_en_out, output, 1, read strobe, one per pixel.
- src_bank_out, output, 1, bank read this octave = octave[0].
- dst_bank_out, output, 1, bank written this octave = ~octave[0].
- half_x_out, output, 8, pixel x to halver, delayed to align with data.
- half_y_out, output, 8, pixel y to halver, delayed to align with data.
- half_valid_out, output, 1, halver data_valid, delayed to align with data.
- new_width_out, output, 8, cur_w>>1; row stride used for destination addressing.
- half_valid_in, input, 1, halver output-valid, used for write counting.
- octave_out, output, 4, current octave index.
- busy_out, output, 1, high from the cycle after an accepted start until done.
- done_out, output, 1, single-cycle pulse at end of pass.
- error_out, output, 1, sticky write-count mismatch; cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n_in=0): state IDLE.
  - All outputs 0: addr, rd_en, banks, half_x/y/valid, new_width, octave, busy, done, error.
  - Delay line and counters cleared.
  - Asserting reset mid-pass aborts immediately; no done_out pulse is produced.
- Per octave k: cur_w=WIDTH>>k, cur_h=HEIGHT>>k, expected writes = (cur_w>>1)*(cur_h>>1).
- State machine:
  - IDLE:
    - start_in=1 -> READ next cycle.
    - Set octave=0, x=y=0, error=0, busy=1.
  - READ:
    - Each cycle: src_rd_en_out=1, src_addr_out=y*cur_w+x.
    - x increments; at x=cur_w-1, x wraps to 0 and y increments.
    - After the read with x=cur_w-1 and y=cur_h-1, go to DRAIN. READ lasts exactly cur_w*cur_h cycles with no gaps.
  - DRAIN:
    - src_rd_en_out=0.
    - Hold for BRAM_LATENCY+2 cycles so the final half_valid_in is counted, then go to CHECK.
  - CHECK (1 cycle):
    - If write count != expected, set error_out.
    - If octave==OCTAVES-1, go to DONE; else increment octave, clear x/y and count, go to READ.
  - DONE (1 cycle): done_out=1, busy_out=0, then IDLE.
- Alignment: half_x/y/valid_out equal the x/y/rd_en of the read issued exactly BRAM_LATENCY cycles earlier (registered shift line of depth BRAM_LATENCY).
- Write counter:
  - Increments on every half_valid_in=1 while state is READ or DRAIN, 16-bit.
  - half_valid_in in IDLE/CHECK/DONE is ignored, except in CHECK, where a pulse also sets error_out.
- Banks, new_width_out and octave_out update in the CHECK->READ transition cycle and are stable throughout the octave.
- start_in while busy: ignored, with no effect on state or error.
- start_in asserted in the same cycle as DONE: ignored; a new pass requires start_in in IDLE.
- Arithmetic: address and expected count computed at 16 bits; no overflow for dimensions up to 256x256.

Test Plan:
- WIDTH=8, HEIGHT=4, OCTAVES=2, BRAM_LATENCY=2, with the real halver attached; pulse start_in.
  - Octave 0: 32 reads, addresses 0..31, src_bank=0, dst_bank=1, new_width=4, 8 writes counted.
  - Octave 1: 8 reads, addresses 0..7, src_bank=1, dst_bank=0, new_width=2, 2 writes.
  - done_out pulses once; error_out=0.
- Alignment check: src_rd_en_out first high at cycle T with addr 0 -> half_valid_out=1 with half_x=half_y=0 at T+2; address 9 (x=1, y=1) appears as half_x=1, half_y=1 two cycles later.
- Halver replaced by a model that drops one valid in octave 0 -> error_out=1 from the CHECK cycle, stays 1 through done_out; the next start clears it.
- start_in pulsed mid-READ and again in the done_out cycle -> no restart, read sequence unchanged, exactly one done per accepted start.
- rst_n_in driven low mid-octave-1 (asynchronously, between clock edges) -> all outputs 0 immediately, no done_out pulse; a subsequent start runs a full correct pass from octave 0.

Source files
------------

// File: rtl/image_half_sequencer.sv
// Raster-scan sequencer for the image-halving datapath: drives BRAM reads, aligns x/y/valid
// with returned pixel data, counts halver writes and ping-pongs banks over OCTAVES halvings.
module image_half_sequencer #(
  parameter int BIT_DEPTH    = 8,
  parameter int WIDTH        = 64,
  parameter int HEIGHT       = 64,
  parameter int OCTAVES      = 3,
  parameter int BRAM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  output logic [15:0] src_addr_out,
  output logic        src_rd_en_out,
  output logic        src_bank_out,
  output logic        dst_bank_out,
  output logic [7:0]  half_x_out,
  output logic [7:0]  half_y_out,
  output logic        half_valid_out,
  output logic [7:0]  new_width_out,
  input  logic        half_valid_in,
  output logic [3:0]  octave_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        error_out
);

  if (BIT_DEPTH < 1 || BRAM_LATENCY < 1 || OCTAVES < 1 || OCTAVES > 15 ||
      WIDTH > 256 || HEIGHT > 256 ||
      (WIDTH >> OCTAVES) < 1 || (HEIGHT >> OCTAVES) < 1) begin : g_bad_params
    $error("image_half_sequencer: unsupported parameter combination");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0] DRAIN_LAST = 8'(BRAM_LATENCY + 1);
  localparam logic [3:0] LAST_OCT   = 4'(OCTAVES - 1);

  typedef struct packed {
    logic       v;
    logic [7:0] x;
    logic [7:0] y;
  } tap_t;

  logic [2:0]  state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [3:0]  octave_q, octave_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [7:0]  drain_q, drain_d;
  logic        error_q, error_d;
  logic [7:0]  new_width_q, new_width_d;
  logic        dst_bank_q, dst_bank_d;
  tap_t        tap_in;
  tap_t        pipe_q [BRAM_LATENCY];

  // Geometry of the octave currently being read; all power-of-two shifts.
  logic [15:0] cur_w, cur_h, exp_writes, rd_addr;
  logic        reading;

  assign cur_w      = 16'(WIDTH) >> octave_q;
  assign cur_h      = 16'(HEIGHT) >> octave_q;
  assign exp_writes = (cur_w >> 1) * (cur_h >> 1);
  assign rd_addr    = 16'(y_q) * cur_w + 16'(x_q);
  assign reading    = (state_q == S_READ);

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latches).
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    octave_d    = octave_q;
    wr_cnt_d    = wr_cnt_q;
    drain_d     = drain_q;
    error_d     = error_q;
    new_width_d = new_width_q;
    dst_bank_d  = dst_bank_q;

    if ((state_q == S_READ || state_q == S_DRAIN) && half_valid_in) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d     = S_READ;
          octave_d    = 4'd0;
          x_d         = 8'd0;
          y_d         = 8'd0;
          wr_cnt_d    = 16'd0;
          error_d     = 1'b0;
          new_width_d = 8'(WIDTH >> 1);
          dst_bank_d  = 1'b1;
        end
      end
      S_READ: begin
        if (16'(x_q) == cur_w - 16'd1) begin
          x_d = 8'd0;
          if (16'(y_q) == cur_h - 16'd1) begin
            y_d     = 8'd0;
            drain_d = 8'd0;
            state_d = S_DRAIN;
          end else begin
            y_d = y_q + 8'd1;
          end
        end else begin
          x_d = x_q + 8'd1;
        end
      end
      S_DRAIN: begin
        // Wait long enough for the last pixel to pass BRAM and halver before judging the count.
        if (drain_q == DRAIN_LAST) begin
          state_d = S_CHECK;
        end else begin
          drain_d = drain_q + 8'd1;
        end
      end
      S_CHECK: begin
        if (wr_cnt_q != exp_writes || half_valid_in) begin
          error_d = 1'b1;
        end
        if (octave_q == LAST_OCT) begin
          state_d = S_DONE;
        end else begin
          state_d     = S_READ;
          octave_d    = octave_q + 4'd1;
          x_d         = 8'd0;
          y_d         = 8'd0;
          wr_cnt_d    = 16'd0;
          new_width_d = 8'(cur_w >> 2);
          dst_bank_d  = octave_q[0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      x_q         <= 8'd0;
      y_q         <= 8'd0;
      octave_q    <= 4'd0;
      wr_cnt_q    <= 16'd0;
      drain_q     <= 8'd0;
      error_q     <= 1'b0;
      new_width_q <= 8'd0;
      dst_bank_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      octave_q    <= octave_d;
      wr_cnt_q    <= wr_cnt_d;
      drain_q     <= drain_d;
      error_q     <= error_d;
      new_width_q <= new_width_d;
      dst_bank_q  <= dst_bank_d;
    end
  end

  // Coordinates travel alongside the read so they meet the returned pixel at the halver.
  always_comb begin
    tap_in.v = reading;
    tap_in.x = reading ? x_q : 8'd0;
    tap_in.y = reading ? y_q : 8'd0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      // NOTE: this is a short control shift line, not a memory, so every stage is reset.
      for (int i = 0; i < BRAM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tap_in;
      for (int i = 1; i < BRAM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign src_rd_en_out  = reading;
  assign src_addr_out   = reading ? rd_addr : 16'd0;
  assign src_bank_out   = octave_q[0];
  assign dst_bank_out   = dst_bank_q;
  assign half_valid_out = pipe_q[BRAM_LATENCY-1].v;
  assign half_x_out     = pipe_q[BRAM_LATENCY-1].x;
  assign half_y_out     = pipe_q[BRAM_LATENCY-1].y;
  assign new_width_out  = new_width_q;
  assign octave_out     = octave_q;
  assign busy_out       = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_CHECK);
  assign done_out       = (state_q == S_DONE);
  assign error_out      = error_q;

endmodule

// File: tb/tb_image_half_sequencer.sv
// Directed-random bench for image_half_sequencer: a pixel-level reference of the pyramid
// read stream plus a behavioural halver that writes one pixel per 2x2 block.
module tb_image_half_sequencer;
  localparam int W   = 8;
  localparam int H   = 4;
  localparam int OCT = 2;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        hv_in = 1'b0;
  logic [15:0] src_addr_out;
  logic        src_rd_en_out, src_bank_out, dst_bank_out;
  logic [7:0]  half_x_out, half_y_out, new_width_out;
  logic        half_valid_out;
  logic [3:0]  octave_out;
  logic        busy_out, done_out, error_out;

  image_half_sequencer #(
    .BIT_DEPTH(8), .WIDTH(W), .HEIGHT(H), .OCTAVES(OCT), .BRAM_LATENCY(LAT)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start),
    .src_addr_out(src_addr_out), .src_rd_en_out(src_rd_en_out),
    .src_bank_out(src_bank_out), .dst_bank_out(dst_bank_out),
    .half_x_out(half_x_out), .half_y_out(half_y_out), .half_valid_out(half_valid_out),
    .new_width_out(new_width_out), .half_valid_in(hv_in), .octave_out(octave_out),
    .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int x;
    int y;
    int oct;
    bit first;
    bit err;
  } rd_t;

  rd_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  logic drop_en = 1'b0;
  logic dropped = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural halver: one write per 2x2 block, optionally losing the first octave-0 write.
  always @(posedge clk) begin
    if (!drop_en) dropped <= 1'b0;
    if (half_valid_out && !half_x_out[0] && !half_y_out[0]) begin
      if (drop_en && !dropped && octave_out == 4'd0) begin
        dropped <= 1'b1;
        hv_in   <= 1'b0;
      end else begin
        hv_in <= 1'b1;
      end
    end else begin
      hv_in <= 1'b0;
    end
  end

  // Monitor: every read must match the planned raster order; half_* must replay it LAT later.
  logic h_v [LAT];
  int   h_x [LAT];
  int   h_y [LAT];
  bit   prev_rd = 1'b0;
  rd_t  it;
  logic cur_v;
  int   cur_x, cur_y;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin h_v[i] = 1'b0; h_x[i] = 0; h_y[i] = 0; end
      prev_rd = 1'b0;
    end else begin
      check("half_valid", 32'(half_valid_out), 32'(h_v[LAT-1]));
      if (h_v[LAT-1]) begin
        check("half_x", 32'(half_x_out), h_x[LAT-1]);
        check("half_y", 32'(half_y_out), h_y[LAT-1]);
      end
      cur_v = 1'b0; cur_x = 0; cur_y = 0;
      if (src_rd_en_out) begin
        if (exp_q.size() == 0) begin
          check("spurious_read", 32'd1, 32'd0);
        end else begin
          it = exp_q.pop_front();
          check("rd_addr", 32'(src_addr_out), it.addr);
          check("rd_octave", 32'(octave_out), it.oct);
          check("src_bank", 32'(src_bank_out), it.oct % 2);
          check("dst_bank", 32'(dst_bank_out), 1 - (it.oct % 2));
          check("new_width", 32'(new_width_out), (W >> it.oct) / 2);
          check("busy_in_read", 32'(busy_out), 32'd1);
          check("error_in_read", 32'(error_out), 32'(it.err));
          if (!it.first) check("read_gap", 32'(prev_rd), 32'd1);
          cur_v = 1'b1; cur_x = it.x; cur_y = it.y;
        end
      end
      if (done_out) done_cnt++;
      for (int i = LAT - 1; i > 0; i--) begin
        h_v[i] = h_v[i-1]; h_x[i] = h_x[i-1]; h_y[i] = h_y[i-1];
      end
      h_v[0] = cur_v; h_x[0] = cur_x; h_y[0] = cur_y;
      prev_rd = src_rd_en_out;
    end
  end

  task automatic plan_pass(input bit drop);
    for (int k = 0; k < OCT; k++) begin
      int cw = W >> k;
      int ch = H >> k;
      for (int a = 0; a < cw * ch; a++) begin
        rd_t r;
        r.addr = a; r.x = a % cw; r.y = a / cw; r.oct = k;
        r.first = (a == 0); r.err = drop && (k > 0);
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic check_all_zero();
    check("rst_addr", 32'(src_addr_out), 32'd0);
    check("rst_rd_en", 32'(src_rd_en_out), 32'd0);
    check("rst_src_bank", 32'(src_bank_out), 32'd0);
    check("rst_dst_bank", 32'(dst_bank_out), 32'd0);
    check("rst_half_x", 32'(half_x_out), 32'd0);
    check("rst_half_y", 32'(half_y_out), 32'd0);
    check("rst_half_valid", 32'(half_valid_out), 32'd0);
    check("rst_new_width", 32'(new_width_out), 32'd0);
    check("rst_octave", 32'(octave_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_error", 32'(error_out), 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    check("idle_before_start", 32'(busy_out), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy_out), 32'd1);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_out) begin ok = 1'b1; return; end
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_pass(input bit drop, input bit stray);
    int base;
    bit ok;
    base = done_cnt;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    drop_en = drop;
    plan_pass(drop);
    pulse_start();
    if (stray) begin
      repeat ($urandom_range(2, 20)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(ok);
    if (ok) begin
      check("error_at_done", 32'(error_out), 32'(drop));
      check("busy_at_done", 32'(busy_out), 32'd0);
      if (stray) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_single_pulse", 32'(done_out), 32'd0);
      check("error_after_done", 32'(error_out), 32'(drop));
      repeat (8) @(negedge clk);
      check("idle_after_done", 32'(busy_out), 32'd0);
      check("no_restart_read", 32'(src_rd_en_out), 32'd0);
      check("done_count", done_cnt, base + 1);
      check("all_reads_seen", exp_q.size(), 32'd0);
    end
    exp_q.delete();
    drop_en = 1'b0;
  endtask

  initial begin
    int base;
    bit seen;
    #12;
    check_all_zero();
    @(posedge clk); #2 rst_n = 1'b1;

    run_pass(1'b0, 1'b1);
    run_pass(1'b1, 1'b0);
    run_pass(1'b0, 1'b1);

    // Abort in octave 1 with an asynchronous reset between clock edges.
    base = done_cnt;
    plan_pass(1'b0);
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (octave_out == 4'd1) seen = 1'b1;
    end
    check("reach_octave1", 32'(seen), 32'd1);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check_all_zero();
    exp_q.delete();
    repeat (4) @(negedge clk);
    check("no_done_on_abort", done_cnt, base);
    check("abort_stays_idle", 32'(busy_out), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;

    run_pass(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
